// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared control-bus encodings, redirect defaults and FSM state type
package pipe_ctrl_pkg;
  localparam int CTRL_W = 6;
  localparam logic STOP = 1'b1;
  localparam logic NOSTOP = 1'b0;
  localparam logic [CTRL_W-1:0] STALL_NONE = {CTRL_W{NOSTOP}};
  localparam logic [CTRL_W-1:0] STALL_ID = {{3{NOSTOP}}, {3{STOP}}};
  localparam logic [CTRL_W-1:0] STALL_EX = {{2{NOSTOP}}, {4{STOP}}};
  localparam logic [CTRL_W-1:0] STALL_MEM = {NOSTOP, {5{STOP}}};
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
  typedef enum logic {RUN, MASK} state_t;
endpackage

// File: rtl/stall_wdt.sv
// stall_wdt: stalled-cycle performance counter plus consecutive-stall watchdog with sticky flag
module stall_wdt #(
  parameter int WDT_LIMIT = 1024,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);
  localparam int RW = $clog2(WDT_LIMIT + 1);
  localparam logic [RW-1:0] LIM = RW'(WDT_LIMIT);
  logic [RW-1:0] run;
  logic [RW-1:0] run_nx;
  logic          hit;
  // run length of the current stall streak, saturating so the flag fires only on arrival
  always_comb begin
    run_nx = (stop && !flush) ? ((run == LIM) ? run : run + RW'(1)) : '0;
    hit = stop && !flush && (run == LIM - RW'(1));
  end
  // counters and sticky flag; clear wins over both increment and set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= '0;
      stall_cnt <= '0;
      stall_timeout <= 1'b0;
    end else begin
      run <= run_nx;
      stall_cnt <= cnt_clr ? '0 : (stop && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
      stall_timeout <= cnt_clr ? 1'b0 : (stall_timeout || hit);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall priority, exception/ERET redirect with masking window, and stall accounting
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int MASK_CYCLES = 2,
  parameter int WDT_LIMIT = 1024,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              exc_valid,
  input  logic              exc_eret,
  input  logic [31:0]       exc_epc,
  input  logic              cnt_clr,
  output logic [CTRL_W-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);
  localparam int MW = (MASK_CYCLES > 1) ? $clog2(MASK_CYCLES) : 1;
  localparam logic [MW-1:0] MLOAD = MW'((MASK_CYCLES > 0) ? MASK_CYCLES - 1 : 0);
  state_t        state;
  state_t        state_nx;
  logic [MW-1:0] mcnt;
  logic [MW-1:0] mcnt_nx;
  logic          exc_acc;
  // zero-latency control outputs; held quiet while reset is asserted
  always_comb begin
    exc_acc = rst && exc_valid && (state == RUN);
    flush = exc_acc;
    new_pc = exc_acc ? (exc_eret ? exc_epc : EXC_VECTOR) : '0;
    stall = (!rst || exc_acc) ? STALL_NONE :
            stallreq_mem ? STALL_MEM :
            stallreq_ex ? STALL_EX :
            stallreq_id ? STALL_ID : STALL_NONE;
  end
  // masking FSM: an accepted redirect blocks further exceptions for MASK_CYCLES cycles
  always_comb begin
    state_nx = (state == RUN) ? ((exc_acc && MASK_CYCLES > 0) ? MASK : RUN) :
               ((mcnt == '0) ? RUN : MASK);
    mcnt_nx = (state == RUN) ? MLOAD : ((mcnt == '0) ? '0 : mcnt - MW'(1));
  end
  // FSM state and mask counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      mcnt <= '0;
    end else begin
      state <= state_nx;
      mcnt <= mcnt_nx;
    end
  end
  stall_wdt #(.WDT_LIMIT(WDT_LIMIT), .CNT_W(CNT_W)) u_wdt (
    .clk(clk),
    .rst(rst),
    .stop(stall[0]),
    .flush(flush),
    .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt),
    .stall_timeout(stall_timeout)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench with a cycle-level reference model of pipe_ctrl
module tb_pipe_ctrl;
  localparam int MASKC = 2;
  localparam int WDT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id = 1'b0, ex = 1'b0, mem = 1'b0, ev = 1'b0, er = 1'b0, clr = 1'b0;
  logic [31:0] epc = '0;
  logic [5:0] stall;
  logic flush, timeout;
  logic [31:0] new_pc, cnt;
  int n = 0;
  int errs = 0;
  typedef struct {
    logic [5:0] stall;
    logic flush;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic to;
  } exp_t;
  exp_t q[$];
  int m_mask, m_run;
  logic [31:0] m_cnt;
  logic m_to;

  pipe_ctrl #(.EXC_VECTOR(32'h20), .MASK_CYCLES(MASKC), .WDT_LIMIT(WDT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex), .stallreq_mem(mem),
    .exc_valid(ev), .exc_eret(er), .exc_epc(epc), .cnt_clr(clr),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cnt(cnt), .stall_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_mask = 0;
    m_run = 0;
    m_cnt = 0;
    m_to = 1'b0;
  endtask

  task automatic cyc(input logic i_id, i_ex, i_mem, i_ev, i_er, input logic [31:0] i_epc, input logic i_clr);
    exp_t e;
    logic acc;
    @(negedge clk);
    id = i_id; ex = i_ex; mem = i_mem; ev = i_ev; er = i_er; epc = i_epc; clr = i_clr;
    acc = i_ev && m_mask == 0;
    e.flush = acc;
    e.pc = acc ? (i_er ? i_epc : 32'h20) : 32'h0;
    e.stall = acc ? 6'd0 : i_mem ? 6'b011111 : i_ex ? 6'b001111 : i_id ? 6'b000111 : 6'd0;
    e.cnt = m_cnt;
    e.to = m_to;
    q.push_back(e);
    if (acc) m_mask = MASKC;
    else if (m_mask > 0) m_mask--;
    if (i_clr) m_to = 1'b0;
    else if (e.stall[0] && m_run == WDT - 1) m_to = 1'b1;
    if (i_clr) m_cnt = 0;
    else if (e.stall[0] && m_cnt != 32'hffff_ffff) m_cnt++;
    m_run = e.stall[0] ? ((m_run < WDT) ? m_run + 1 : WDT) : 0;
  endtask

  // monitor: every cycle with a pending expectation, compare the DUT against it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {26'd0, stall}, {26'd0, e.stall});
        chk("flush", {31'd0, flush}, {31'd0, e.flush});
        chk("new_pc", new_pc, e.pc);
        chk("stall_cnt", cnt, e.cnt);
        chk("stall_timeout", {31'd0, timeout}, {31'd0, e.to});
      end
    end
  end

  initial begin
    model_reset();
    mem = 1'b1; ev = 1'b1;
    #2;
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pc", new_pc, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_to", {31'd0, timeout}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 32'hdead_beef, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_1234, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("cnt_seven", cnt, 32'd7);
    chk("timeout_set", {31'd0, timeout}, 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    #3 rst = 1'b0;
    #1;
    chk("async_stall", {26'd0, stall}, 32'd0);
    chk("async_flush", {31'd0, flush}, 32'd0);
    chk("async_pc", new_pc, 32'd0);
    chk("async_cnt", cnt, 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    cyc(0, 0, 1, 1, 1, 32'h0000_0abc, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (400) cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
                     $urandom_range(0, 9) < 1, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 29) == 0);
    @(negedge clk);
    id = 0; ex = 0; mem = 0; ev = 0; er = 0; clr = 0;
    #4;
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
